// File: rtl/data_memory_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port synchronous data memory.
// Round-robin on ties, one access per four cycles: IDLE -> ACCESS -> WAIT -> DONE.
module data_memory_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          busy,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          last_gnt_q;   // 1 = debug port won last
    logic          sel_q;        // 1 = debug port owns the access
    logic          we_q;
    logic [AW-1:0] mem_address_q;
    logic [DW-1:0] mem_data_q;
    logic          mem_wren_q;
    logic          cpu_ack_q;
    logic          dbg_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;
    logic          busy_q;

    logic          any_req_d;
    logic          pick_dbg_d;
    logic          win_we_d;
    logic [AW-1:0] win_addr_d;
    logic [DW-1:0] win_wdata_d;

    always_comb begin
        any_req_d   = cpu_req | dbg_req;
        // Debug wins when alone, or on a tie when the CPU was served last.
        pick_dbg_d  = dbg_req & (~cpu_req | ~last_gnt_q);
        win_we_d    = pick_dbg_d ? dbg_we    : cpu_we;
        win_addr_d  = pick_dbg_d ? dbg_addr  : cpu_addr;
        win_wdata_d = pick_dbg_d ? dbg_wdata : cpu_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_gnt_q    <= 1'b1;
            sel_q         <= 1'b0;
            we_q          <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dbg_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            dbg_rdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            cpu_ack_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
            mem_wren_q <= 1'b0;
            mem_data_q <= '0;
            case (state_q)
                S_IDLE: begin
                    mem_address_q <= '0;
                    if (!hold && any_req_d) begin
                        sel_q         <= pick_dbg_d;
                        last_gnt_q    <= pick_dbg_d;
                        we_q          <= win_we_d;
                        mem_address_q <= win_addr_d;
                        mem_data_q    <= win_wdata_d;
                        mem_wren_q    <= win_we_d;
                        busy_q        <= 1'b1;
                        state_q       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Address is held through WAIT; data and write enable drop.
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!we_q) begin
                        if (sel_q) dbg_rdata_q <= mem_q;
                        else       cpu_rdata_q <= mem_q;
                    end
                    cpu_ack_q     <= ~sel_q;
                    dbg_ack_q     <= sel_q;
                    mem_address_q <= '0;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q        <= 1'b0;
                    mem_address_q <= '0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign dbg_ack     = dbg_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign busy        = busy_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a driver issues requests and pushes
// expected completions; a negedge monitor checks memory traffic and acks.
module tb_data_memory_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          hold = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          cpu_ack, dbg_ack, busy, mem_wren;
    logic [DW-1:0] cpu_rdata, dbg_rdata, mem_data;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_q = '0;

    data_memory_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .busy(busy), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Environment: synchronous single-port RAM, read data one cycle after address.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    // Reference model: expected service order and read results.
    typedef struct {
        bit            who;      // 1 = dbg
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_c;
        logic [DW-1:0] exp_d;
    } txn_t;

    txn_t          sb[$];
    logic [DW-1:0] shadow [0:65535];
    logic [DW-1:0] rc_m, rd_m;
    bit            last_m;
    int            wren_cnt = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen at %0t", name, $time);
    endtask

    function automatic void model_reset();
        sb.delete();
        wren_cnt = 0;
        rc_m = '0;
        rd_m = '0;
        last_m = 1'b1;
    endfunction

    function automatic void push_txn(input bit who, input bit we,
                                     input logic [AW-1:0] a, input logic [DW-1:0] wd);
        txn_t t;
        if (we) shadow[a] = wd;
        else if (who) rd_m = shadow[a];
        else rc_m = shadow[a];
        last_m = who;
        t.who = who; t.we = we; t.addr = a; t.wdata = wd; t.exp_c = rc_m; t.exp_d = rd_m;
        sb.push_back(t);
    endfunction

    // Monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_wren) begin
                if (sb.size() == 0) fail("wren_unexpected");
                else begin
                    chk("wren_addr", 32'(mem_address), 32'(sb[0].addr));
                    chk("wren_data", 32'(mem_data), 32'(sb[0].wdata));
                    wren_cnt++;
                end
            end
            if (cpu_ack || dbg_ack) begin
                if (sb.size() == 0) fail("ack_unexpected");
                else begin
                    txn_t t;
                    t = sb.pop_front();
                    chk("ack_who", {30'd0, cpu_ack, dbg_ack}, t.who ? 32'd1 : 32'd2);
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(t.exp_c));
                    chk("dbg_rdata", 32'(dbg_rdata), 32'(t.exp_d));
                    chk("wren_cycles", 32'(wren_cnt), 32'(t.we));
                    wren_cnt = 0;
                end
            end
        end
    end

    // One request round from IDLE: single or simultaneous requests.
    task automatic run(input bit c, input bit d,
                       input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                       input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input bit drop_early, input bit mid_hold);
        bit first;
        bit c_pend, d_pend;
        int n;
        @(negedge clock);
        cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
        dbg_req = d; dbg_we = dw; dbg_addr = da; dbg_wdata = dwd;
        first = (c && d) ? ~last_m : d;
        if (first) push_txn(1'b1, dw, da, dwd); else push_txn(1'b0, cw, ca, cwd);
        if (c && d) begin
            if (first) push_txn(1'b0, cw, ca, cwd); else push_txn(1'b1, dw, da, dwd);
        end
        c_pend = c; d_pend = d; n = 0;
        while ((c_pend || d_pend) && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                if (drop_early) begin cpu_req = 1'b0; dbg_req = 1'b0; end
                if (mid_hold) hold = 1'b1;
            end
            if (cpu_ack && c_pend) begin
                c_pend = 1'b0; cpu_req = 1'b0; hold = 1'b0;
                chk("cpu_latency", 32'(n), (first == 1'b0) ? 32'd3 : 32'd7);
            end
            if (dbg_ack && d_pend) begin
                d_pend = 1'b0; dbg_req = 1'b0; hold = 1'b0;
                chk("dbg_latency", 32'(n), (first == 1'b1) ? 32'd3 : 32'd7);
            end
        end
        if (c_pend || d_pend) fail("ack_timeout");
        cpu_req = 1'b0; dbg_req = 1'b0; hold = 1'b0;
    endtask

    initial begin
        int n;
        for (int unsigned i = 0; i < 65536; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        model_reset();

        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
        reset = 1'b0;

        // CPU write, debug read back
        run(1, 0, 1, 16'h0010, 16'hBEEF, 0, 16'h0, 16'h0, 0, 0);
        run(0, 1, 0, 16'h0, 16'h0, 0, 16'h0010, 16'h0, 0, 0);

        // Three ties
        repeat (3) run(1, 1, 1, 16'h0011, DW'($urandom), 0, 16'h0011, 16'h0, 0, 0);

        // hold blocks grants; release grants on the next edge
        @(negedge clock);
        hold = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        repeat (10) begin
            @(negedge clock);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_wren", 32'(mem_wren), 32'd0);
        end
        hold = 1'b0;
        push_txn(1'b0, 1'b0, 16'h0010, 16'h0);
        @(negedge clock);
        chk("hold_release_busy", 32'(busy), 32'd1);
        n = 1;
        while (!cpu_ack && n < 10) begin @(negedge clock); n++; end
        chk("hold_release_latency", 32'(n), 32'd3);
        cpu_req = 1'b0;

        // Debug request dropped during ACCESS still completes
        run(0, 1, 0, 16'h0, 16'h0, 0, 16'h0010, 16'h0, 1, 0);

        // Reset during WAIT aborts a read
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        push_txn(1'b0, 1'b0, 16'h0010, 16'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clock);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        chk("abort_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
        chk("abort_wren", 32'(mem_wren), 32'd0);
        model_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        run(1, 0, 0, 16'h0010, 16'h0, 0, 16'h0, 16'h0, 0, 0);

        // Randomised traffic
        for (int unsigned k = 0; k < 60; k++) begin
            bit c, d;
            c = 1'($urandom);
            d = 1'($urandom);
            if (!c && !d) c = 1'b1;
            run(c, d,
                1'($urandom), AW'($urandom_range(32, 39)), DW'($urandom),
                1'($urandom), AW'($urandom_range(32, 39)), DW'($urandom),
                (c ^ d) && ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        repeat (6) @(negedge clock);
        if (sb.size() != 0) fail("scoreboard_not_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
